mu0_control: RTL
================

MU0_CONTROL -- requirements
Module: MU0_Control

Interface
REQ-001 The block SHALL have no parameters; all behaviour is fixed except REQ-030.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 nReset  input  1  reset; synchronous and active-low.
REQ-004 F  input  4  opcode, i.e. the top nibble of the instruction register.
REQ-005 N  input  1  accumulator negative flag (Acc[15]).
REQ-006 Z  input  1  accumulator zero flag (Acc == 0).
REQ-007 Mem_rdy  input  1  memory ready; present only when REQ-030 is compiled in.
REQ-008 X_sel  output  1  ALU X source: 0 = PC, 1 = Acc.
REQ-009 Y_sel  output  1  ALU Y source: 0 = memory data, 1 = IR operand.
REQ-010 Addr_sel  output  1  address source: 0 = PC, 1 = IR operand.
REQ-011 M  output  2  ALU function code: 00 pass Y, 01 X+Y, 10 X+1, 11 X-Y.
REQ-012 PC_En, IR_En, Acc_En  output  1 each  register load enables.
REQ-013 Rd, Wr  output  1 each  memory read and write strobes.
REQ-014 Halted  output  1  high while in HALT.
REQ-015 InstrCount  output  16  count of retired instructions.

Function
REQ-016 The FSM SHALL have three states: FETCH, EXEC, HALT; outputs are decoded combinationally from state, F, N and Z.
REQ-017 Transitions SHALL be: FETCH->EXEC; EXEC->FETCH for F=0..6; EXEC->HALT for F=7..F; HALT->HALT until reset.
REQ-018 FETCH SHALL assert Addr_sel=0, Rd=1, IR_En=1, X_sel=0, M=10, PC_En=1; all other enables 0.
REQ-019 EXEC, F=0 (LDA), SHALL assert Addr_sel=1, Rd=1, Y_sel=0, M=00, Acc_En=1.
REQ-020 EXEC, F=1 (STO), SHALL assert Addr_sel=1, Wr=1, Rd=0, all enables 0.
REQ-021 EXEC, F=2 (ADD) / F=3 (SUB), SHALL assert Addr_sel=1, Rd=1, X_sel=1, Y_sel=0, Acc_En=1, with M=01 for ADD and M=11 for SUB.
REQ-022 EXEC, F=4 (JMP), SHALL assert Y_sel=1, M=00, PC_En=1.
REQ-023 EXEC, F=5 (JGE), SHALL drive as for JMP but with PC_En=~N.
REQ-024 EXEC, F=6 (JNE), SHALL drive as for JMP but with PC_En=~Z.
REQ-025 EXEC for F=7 (STP) and for undefined opcodes 8..F SHALL assert no enables and no strobes.
REQ-026 HALT SHALL drive every enable and strobe to 0, M=00, all selects 0, and Halted=1.
REQ-027 Each instruction SHALL take exactly 2 cycles when no wait states occur.
REQ-028 InstrCount SHALL increment by 1 at the edge leaving EXEC (STP and undefined opcodes included), SHALL wrap from FFFF to 0000, and SHALL never change in HALT.
REQ-029 Rd and Wr SHALL never be high in the same cycle.

Reset
REQ-031 When nReset=0 at a rising edge, the block SHALL enter FETCH and clear InstrCount to 0000, regardless of current state, Mem_rdy or F.
REQ-032 Reset SHALL be the only exit from HALT.
REQ-033 Outputs in the first cycle after reset SHALL equal the FETCH decode of REQ-018.

Configuration
REQ-030 With MU0_MEM_WAIT_EN defined, the Mem_rdy port SHALL exist and the following wait-state rules apply:
- In any cycle with Rd or Wr high and Mem_rdy=0, the state holds.
- During such a hold, PC_En, IR_En and Acc_En are forced to 0, while Rd, Wr, selects and M stay stable.
- The state advances in the first cycle with Mem_rdy=1.
- Cycles with no memory access ignore Mem_rdy.
- Without the macro, the Mem_rdy port is absent and every access completes in one cycle.

Verification
REQ-034 Reset, then F=0 held: cycle 1 FETCH (M=10, PC_En=1, IR_En=1); cycle 2 EXEC (Acc_En=1, M=00, Addr_sel=1); InstrCount=0001 after cycle 2.
REQ-035 EXEC with F=5: N=1 gives PC_En=0; N=0 gives PC_En=1, Y_sel=1, M=00. EXEC with F=6: Z=1 gives PC_En=0.
REQ-036 EXEC with F=3 -> M=11, X_sel=1, Rd=1, Acc_En=1. EXEC with F=1 -> Wr=1, Rd=0, Acc_En=0.
REQ-037 EXEC with F=7, and separately F=A -> HALT with Halted=1 and all enables 0; InstrCount stays constant for 10 further cycles; nReset=0 -> FETCH with InstrCount=0000.
REQ-038 Preload InstrCount to FFFF via 65535 retired instructions, then retire one more -> InstrCount=0000.
REQ-039 MU0_MEM_WAIT_EN defined, Mem_rdy=0 for 3 cycles in FETCH -> state holds, Rd=1, PC_En=IR_En=0; Mem_rdy=1 -> PC_En=IR_En=1, next state EXEC. Assert nReset=0 during a wait -> FETCH.

Source files
------------

// File: rtl/mu0_control.sv
// -----------------------------------------------------------------------------
// mu0_control
//
// Control unit for the MU0 accumulator processor. A three-state FSM
// (FETCH, EXEC, HALT) sequences instruction fetch and execution. All datapath
// controls are decoded combinationally from the current state, the opcode F
// and the accumulator flags N and Z. A 16-bit counter tracks retired
// instructions.
//
// Optional feature (compile-time macro MU0_MEM_WAIT_EN):
//   Adds the Mem_rdy input. Any cycle that asserts Rd or Wr while Mem_rdy is
//   low stalls: the state and counter hold, and the register load enables
//   are suppressed. Selects, M and the strobes remain stable. Without the
//   macro, every memory access completes in a single cycle.
//
// Ports:
//   Clk          in   1   clock, rising edge active
//   nReset       in   1   synchronous, active-low reset
//   F            in   4   opcode (top nibble of IR)
//   N            in   1   accumulator negative flag
//   Z            in   1   accumulator zero flag
//   Mem_rdy      in   1   memory ready (MU0_MEM_WAIT_EN builds only)
//   X_sel        out  1   ALU X source: 0 = PC, 1 = Acc
//   Y_sel        out  1   ALU Y source: 0 = memory data, 1 = IR operand
//   Addr_sel     out  1   address source: 0 = PC, 1 = IR operand
//   M            out  2   ALU function: 00 pass Y, 01 X+Y, 10 X+1, 11 X-Y
//   PC_En        out  1   PC load enable
//   IR_En        out  1   IR load enable
//   Acc_En       out  1   accumulator load enable
//   Rd           out  1   memory read strobe
//   Wr           out  1   memory write strobe
//   Halted       out  1   high while in HALT
//   InstrCount   out  16  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module mu0_control (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [3:0]  F,
    input  logic        N,
    input  logic        Z,
`ifdef MU0_MEM_WAIT_EN
    input  logic        Mem_rdy,
`endif
    output logic        X_sel,
    output logic        Y_sel,
    output logic        Addr_sel,
    output logic [1:0]  M,
    output logic        PC_En,
    output logic        IR_En,
    output logic        Acc_En,
    output logic        Rd,
    output logic        Wr,
    output logic        Halted,
    output logic [15:0] InstrCount
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    // Opcodes
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;

    // ALU function codes
    localparam logic [1:0] ALU_PASS_Y = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_INC_X  = 2'b10;
    localparam logic [1:0] ALU_SUB    = 2'b11;

    state_t      state_q, state_d;
    logic [15:0] instr_count_q, instr_count_d;

    // Raw decode, before any wait-state gating
    logic        dec_x_sel;
    logic        dec_y_sel;
    logic        dec_addr_sel;
    logic [1:0]  dec_m;
    logic        dec_pc_en;
    logic        dec_ir_en;
    logic        dec_acc_en;
    logic        dec_rd;
    logic        dec_wr;
    logic        dec_halted;
    state_t      adv_state;   // where the FSM goes if the cycle completes
    logic        retire;      // this cycle is the last of an instruction
    logic        mem_stall;   // memory access not yet acknowledged

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q       <= ST_FETCH;
            instr_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Decode of outputs and advancing state
    // -------------------------------------------------------------------------
    always_comb begin
        dec_x_sel    = 1'b0;
        dec_y_sel    = 1'b0;
        dec_addr_sel = 1'b0;
        dec_m        = ALU_PASS_Y;
        dec_pc_en    = 1'b0;
        dec_ir_en    = 1'b0;
        dec_acc_en   = 1'b0;
        dec_rd       = 1'b0;
        dec_wr       = 1'b0;
        dec_halted   = 1'b0;
        adv_state    = state_q;
        retire       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // IR <- mem[PC], PC <- PC + 1
                dec_addr_sel = 1'b0;
                dec_rd       = 1'b1;
                dec_ir_en    = 1'b1;
                dec_x_sel    = 1'b0;
                dec_m        = ALU_INC_X;
                dec_pc_en    = 1'b1;
                adv_state    = ST_EXEC;
            end

            ST_EXEC: begin
                retire    = 1'b1;
                // Opcodes 7..F (STP and undefined) stop the machine
                adv_state = (F <= OP_JNE) ? ST_FETCH : ST_HALT;
                case (F)
                    OP_LDA: begin
                        dec_addr_sel = 1'b1;
                        dec_rd       = 1'b1;
                        dec_y_sel    = 1'b0;
                        dec_m        = ALU_PASS_Y;
                        dec_acc_en   = 1'b1;
                    end
                    OP_STO: begin
                        dec_addr_sel = 1'b1;
                        dec_wr       = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        dec_addr_sel = 1'b1;
                        dec_rd       = 1'b1;
                        dec_x_sel    = 1'b1;
                        dec_y_sel    = 1'b0;
                        dec_acc_en   = 1'b1;
                        dec_m        = (F == OP_ADD) ? ALU_ADD : ALU_SUB;
                    end
                    OP_JMP: begin
                        dec_y_sel = 1'b1;
                        dec_m     = ALU_PASS_Y;
                        dec_pc_en = 1'b1;
                    end
                    OP_JGE: begin
                        dec_y_sel = 1'b1;
                        dec_m     = ALU_PASS_Y;
                        dec_pc_en = ~N;
                    end
                    OP_JNE: begin
                        dec_y_sel = 1'b1;
                        dec_m     = ALU_PASS_Y;
                        dec_pc_en = ~Z;
                    end
                    default: begin
                        // STP and undefined opcodes: everything idle
                    end
                endcase
            end

            ST_HALT: begin
                dec_halted = 1'b1;
                adv_state  = ST_HALT;
            end

            default: begin
                adv_state = ST_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Memory wait states
    // -------------------------------------------------------------------------
`ifdef MU0_MEM_WAIT_EN
    // Only cycles that touch memory can be held off by Mem_rdy
    assign mem_stall = (dec_rd | dec_wr) & ~Mem_rdy;
`else
    assign mem_stall = 1'b0;
`endif

    always_comb begin
        state_d       = adv_state;
        instr_count_d = instr_count_q;
        if (mem_stall) begin
            state_d = state_q;
        end else if (retire) begin
            instr_count_d = instr_count_q + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: load enables are suppressed during a stall so that a held
    // cycle never commits; strobes, selects and M stay as decoded.
    // -------------------------------------------------------------------------
    assign X_sel      = dec_x_sel;
    assign Y_sel      = dec_y_sel;
    assign Addr_sel   = dec_addr_sel;
    assign M          = dec_m;
    assign PC_En      = dec_pc_en  & ~mem_stall;
    assign IR_En      = dec_ir_en  & ~mem_stall;
    assign Acc_En     = dec_acc_en & ~mem_stall;
    assign Rd         = dec_rd;
    assign Wr         = dec_wr;
    assign Halted     = dec_halted;
    assign InstrCount = instr_count_q;

endmodule
